// File: rtl/vga_fill_ctrl_if.sv
// Bus bundle for the framebuffer fill engine: MCU pixel writes, fill command,
// status and the single framebuffer write port.
interface vga_fill_ctrl_if #(
   parameter int ADDR_W = 17,
   parameter int X_W    = 9,
   parameter int Y_W    = 8
);
   logic              cpu_wr_valid;
   logic [ADDR_W-1:0] cpu_wr_addr;
   logic [7:0]        cpu_wr_data;
   logic              start;
   logic              abort;
   logic [X_W-1:0]    x0;
   logic [Y_W-1:0]    y0;
   logic [X_W-1:0]    width;
   logic [Y_W-1:0]    height;
   logic [7:0]        color;
   logic              busy;
   logic              done;
   logic              fb_we;
   logic [ADDR_W-1:0] fb_addr;
   logic [7:0]        fb_wdata;

   modport master (
      output cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
      output start, abort, x0, y0, width, height, color,
      input  busy, done, fb_we, fb_addr, fb_wdata
   );

   modport slave (
      input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
      input  start, abort, x0, y0, width, height, color,
      output busy, done, fb_we, fb_addr, fb_wdata
   );
endinterface

// File: rtl/vga_fill_ctrl.sv
// Rectangle fill engine and write-port arbiter for the 320x240 8bpp framebuffer.
// MCU pixel writes always win the port; the fill stalls in place while they occur.
module vga_fill_ctrl #(
   parameter int FB_W   = 320,
   parameter int FB_H   = 240,
   parameter int ADDR_W = 17,
   parameter int X_W    = 9,
   parameter int Y_W    = 8
) (
   input logic            clk,
   input logic            reset,
   vga_fill_ctrl_if.slave bus_io
);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

   localparam logic [X_W:0]      FB_W_X = (X_W+1)'(FB_W);
   localparam logic [Y_W:0]      FB_H_Y = (Y_W+1)'(FB_H);
   localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

   state_e            state_q, state_d;
   logic [X_W-1:0]    cur_x_q, cur_x_d;
   logic [Y_W-1:0]    cur_y_q, cur_y_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [X_W-1:0]    x0_q, x0_d;
   logic [X_W:0]      x_end_q, x_end_d;
   logic [Y_W:0]      y_end_q, y_end_d;
   logic [7:0]        color_q, color_d;
   logic              fb_we_q, fb_we_d;
   logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
   logic [7:0]        fb_wdata_q, fb_wdata_d;

   logic [X_W:0]      x_sum, x_end_clip, next_x;
   logic [Y_W:0]      y_sum, y_end_clip, next_y;
   logic [ADDR_W-1:0] y0_ext;
   logic              degenerate, row_end, last_pixel;

   // Extents are formed one bit wider than the inputs so x0+width cannot wrap.
   always_comb begin
      x_sum      = {1'b0, bus_io.x0} + {1'b0, bus_io.width};
      y_sum      = {1'b0, bus_io.y0} + {1'b0, bus_io.height};
      x_end_clip = (x_sum > FB_W_X) ? FB_W_X : x_sum;
      y_end_clip = (y_sum > FB_H_Y) ? FB_H_Y : y_sum;
      y0_ext     = ADDR_W'(bus_io.y0);
      degenerate = (bus_io.width == '0) || (bus_io.height == '0) ||
                   ({1'b0, bus_io.x0} >= FB_W_X) || ({1'b0, bus_io.y0} >= FB_H_Y);
      next_x     = {1'b0, cur_x_q} + {{X_W{1'b0}}, 1'b1};
      next_y     = {1'b0, cur_y_q} + {{Y_W{1'b0}}, 1'b1};
      row_end    = (next_x >= x_end_q);
      last_pixel = row_end && (next_y >= y_end_q);
   end

   always_comb begin
      state_d    = state_q;
      cur_x_d    = cur_x_q;
      cur_y_d    = cur_y_q;
      row_base_d = row_base_q;
      x0_d       = x0_q;
      x_end_d    = x_end_q;
      y_end_d    = y_end_q;
      color_d    = color_q;
      fb_we_d    = 1'b0;
      fb_addr_d  = fb_addr_q;
      fb_wdata_d = fb_wdata_q;

      if (bus_io.cpu_wr_valid) begin
         fb_we_d    = 1'b1;
         fb_addr_d  = bus_io.cpu_wr_addr;
         fb_wdata_d = bus_io.cpu_wr_data;
      end

      case (state_q)
         IDLE: begin
            if (bus_io.start) begin
               x0_d       = bus_io.x0;
               x_end_d    = x_end_clip;
               y_end_d    = y_end_clip;
               color_d    = bus_io.color;
               cur_x_d    = bus_io.x0;
               cur_y_d    = bus_io.y0;
               // y0*320 as two shifts so no multiplier is needed.
               row_base_d = (y0_ext << 8) + (y0_ext << 6);
               state_d    = degenerate ? DONE : FILL;
            end
         end
         FILL: begin
            if (bus_io.abort) begin
               state_d = IDLE;
            end else if (!bus_io.cpu_wr_valid) begin
               fb_we_d    = 1'b1;
               fb_addr_d  = row_base_q + ADDR_W'(cur_x_q);
               fb_wdata_d = color_q;
               if (last_pixel) begin
                  state_d = DONE;
               end else if (row_end) begin
                  cur_x_d    = x0_q;
                  cur_y_d    = next_y[Y_W-1:0];
                  row_base_d = row_base_q + FB_W_A;
               end else begin
                  cur_x_d = next_x[X_W-1:0];
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cur_x_q    <= '0;
         cur_y_q    <= '0;
         row_base_q <= '0;
         x0_q       <= '0;
         x_end_q    <= '0;
         y_end_q    <= '0;
         color_q    <= '0;
         fb_we_q    <= 1'b0;
         fb_addr_q  <= '0;
         fb_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cur_x_q    <= cur_x_d;
         cur_y_q    <= cur_y_d;
         row_base_q <= row_base_d;
         x0_q       <= x0_d;
         x_end_q    <= x_end_d;
         y_end_q    <= y_end_d;
         color_q    <= color_d;
         fb_we_q    <= fb_we_d;
         fb_addr_q  <= fb_addr_d;
         fb_wdata_q <= fb_wdata_d;
      end
   end

   assign bus_io.busy     = (state_q == FILL);
   assign bus_io.done     = (state_q == DONE);
   assign bus_io.fb_we    = fb_we_q;
   assign bus_io.fb_addr  = fb_addr_q;
   assign bus_io.fb_wdata = fb_wdata_q;

endmodule

// File: tb/tb_vga_fill_ctrl.sv
// Scoreboard bench for vga_fill_ctrl: stimulus queues expected framebuffer writes,
// a negedge monitor pops and compares every fb_we cycle and tallies busy/done cycles.
module tb_vga_fill_ctrl;

   logic clk;
   logic reset;

   vga_fill_ctrl_if bus_if ();

   vga_fill_ctrl dut (
      .clk    (clk),
      .reset  (reset),
      .bus_io (bus_if.slave)
   );

   logic [24:0] expQ[$];
   logic [24:0] expWord;
   int          testsRun;
   int          testsFailed;
   int          busyCycles;
   int          doneCycles;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pushExp(input logic [16:0] addr, input logic [7:0] data);
      expQ.push_back({addr, data});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clearCounts();
      busyCycles = 0;
      doneCycles = 0;
   endtask

   // Pulses start for one cycle; returns 1 time unit after the edge that samples it.
   task automatic applyStimulus(input logic [8:0] x, input logic [7:0] y,
                                input logic [8:0] w, input logic [7:0] h,
                                input logic [7:0] col);
      @(posedge clk);
      #1;
      bus_if.x0     = x;
      bus_if.y0     = y;
      bus_if.width  = w;
      bus_if.height = h;
      bus_if.color  = col;
      bus_if.start  = 1'b1;
      @(posedge clk);
      #1;
      bus_if.start  = 1'b0;
   endtask

   task automatic checkFillEnd(input string name, input int expBusy, input int expDone);
      checkOutput({name, "_busy_cycles"}, busyCycles, expBusy);
      checkOutput({name, "_done_cycles"}, doneCycles, expDone);
      checkOutput({name, "_pending_writes"}, expQ.size(), 0);
   endtask

   // Monitor: every presented framebuffer write must match the head of the queue.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus_if.busy) busyCycles++;
         if (bus_if.done) doneCycles++;
         if (bus_if.fb_we) begin
            if (expQ.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                        bus_if.fb_addr, bus_if.fb_wdata);
            end else begin
               expWord = expQ.pop_front();
               checkOutput("fb_write", {7'd0, bus_if.fb_addr, bus_if.fb_wdata}, {7'd0, expWord});
            end
         end
      end
   end

   initial begin
      testsRun     = 0;
      testsFailed  = 0;
      clearCounts();
      reset               = 1'b1;
      bus_if.cpu_wr_valid = 1'b0;
      bus_if.cpu_wr_addr  = '0;
      bus_if.cpu_wr_data  = '0;
      bus_if.start        = 1'b0;
      bus_if.abort        = 1'b0;
      bus_if.x0           = '0;
      bus_if.y0           = '0;
      bus_if.width        = '0;
      bus_if.height       = '0;
      bus_if.color        = '0;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", bus_if.busy, 0);
      checkOutput("rst_done", bus_if.done, 0);
      checkOutput("rst_fb_we", bus_if.fb_we, 0);
      checkOutput("rst_fb_addr", bus_if.fb_addr, 0);
      checkOutput("rst_fb_wdata", bus_if.fb_wdata, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Basic 2x2 fill at origin
      clearCounts();
      pushExp(17'd0, 8'hE0);
      pushExp(17'd1, 8'hE0);
      pushExp(17'd320, 8'hE0);
      pushExp(17'd321, 8'hE0);
      applyStimulus(9'd0, 8'd0, 9'd2, 8'd2, 8'hE0);
      @(negedge clk);
      checkOutput("basic_busy_first", bus_if.busy, 1);
      idle(8);
      checkFillEnd("basic", 4, 1);

      // Clipped at bottom-right corner
      clearCounts();
      pushExp(17'd76798, 8'h1C);
      pushExp(17'd76799, 8'h1C);
      applyStimulus(9'd318, 8'd239, 9'd5, 8'd3, 8'h1C);
      idle(8);
      checkFillEnd("clip", 2, 1);

      // CPU contention during a 4x1 fill at (10,5)
      clearCounts();
      pushExp(17'd1610, 8'h03);
      pushExp(17'd100, 8'h11);
      pushExp(17'd101, 8'h22);
      pushExp(17'd102, 8'h33);
      pushExp(17'd1611, 8'h03);
      pushExp(17'd1612, 8'h03);
      pushExp(17'd1613, 8'h03);
      applyStimulus(9'd10, 8'd5, 9'd4, 8'd1, 8'h03);
      idle(1);
      bus_if.cpu_wr_valid = 1'b1;
      bus_if.cpu_wr_addr  = 17'd100;
      bus_if.cpu_wr_data  = 8'h11;
      idle(1);
      bus_if.cpu_wr_addr  = 17'd101;
      bus_if.cpu_wr_data  = 8'h22;
      idle(1);
      bus_if.cpu_wr_addr  = 17'd102;
      bus_if.cpu_wr_data  = 8'h33;
      idle(1);
      bus_if.cpu_wr_valid = 1'b0;
      idle(8);
      checkFillEnd("contention", 7, 1);

      // Degenerate rectangles: width 0, x0 off-screen, height 0
      clearCounts();
      applyStimulus(9'd5, 8'd5, 9'd0, 8'd4, 8'h12);
      @(negedge clk);
      checkOutput("degen_w_done", bus_if.done, 1);
      checkOutput("degen_w_busy", bus_if.busy, 0);
      idle(4);
      checkFillEnd("degen_w", 0, 1);

      clearCounts();
      applyStimulus(9'd320, 8'd5, 9'd4, 8'd4, 8'h12);
      @(negedge clk);
      checkOutput("degen_x_done", bus_if.done, 1);
      idle(4);
      checkFillEnd("degen_x", 0, 1);

      clearCounts();
      applyStimulus(9'd5, 8'd5, 9'd4, 8'd0, 8'h12);
      idle(4);
      checkFillEnd("degen_h", 0, 1);

      // Abort in the third FILL cycle of a 10x10 fill at (20,10)
      clearCounts();
      pushExp(17'd3220, 8'h55);
      pushExp(17'd3221, 8'h55);
      applyStimulus(9'd20, 8'd10, 9'd10, 8'd10, 8'h55);
      idle(2);
      bus_if.abort = 1'b1;
      idle(1);
      bus_if.abort = 1'b0;
      @(negedge clk);
      checkOutput("abort_busy_after", bus_if.busy, 0);
      idle(6);
      checkFillEnd("abort", 3, 0);

      // Start pulses mid-fill and during DONE are ignored
      clearCounts();
      pushExp(17'd321, 8'h0F);
      pushExp(17'd322, 8'h0F);
      pushExp(17'd641, 8'h0F);
      pushExp(17'd642, 8'h0F);
      applyStimulus(9'd1, 8'd1, 9'd2, 8'd2, 8'h0F);
      bus_if.x0     = 9'd100;
      bus_if.y0     = 8'd100;
      bus_if.color  = 8'hFF;
      idle(1);
      bus_if.start  = 1'b1;
      idle(1);
      bus_if.start  = 1'b0;
      idle(2);
      bus_if.start  = 1'b1;
      idle(1);
      bus_if.start  = 1'b0;
      idle(6);
      checkFillEnd("ignored_start", 4, 1);

      // CPU write forwarded while idle
      clearCounts();
      pushExp(17'd500, 8'hAB);
      bus_if.cpu_wr_valid = 1'b1;
      bus_if.cpu_wr_addr  = 17'd500;
      bus_if.cpu_wr_data  = 8'hAB;
      idle(1);
      bus_if.cpu_wr_valid = 1'b0;
      idle(2);
      checkFillEnd("cpu_idle", 0, 0);

      // Reset in the middle of a fill, then a fresh basic fill
      clearCounts();
      pushExp(17'd0, 8'h77);
      applyStimulus(9'd0, 8'd0, 9'd10, 8'd10, 8'h77);
      idle(2);
      reset = 1'b1;
      #1;
      checkOutput("midrst_busy", bus_if.busy, 0);
      checkOutput("midrst_done", bus_if.done, 0);
      checkOutput("midrst_fb_we", bus_if.fb_we, 0);
      checkOutput("midrst_pending", expQ.size(), 0);
      idle(2);
      reset = 1'b0;
      clearCounts();
      pushExp(17'd0, 8'hE0);
      pushExp(17'd1, 8'hE0);
      pushExp(17'd320, 8'hE0);
      pushExp(17'd321, 8'hE0);
      applyStimulus(9'd0, 8'd0, 9'd2, 8'd2, 8'hE0);
      idle(8);
      checkFillEnd("post_reset", 4, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
